// File: rtl/float64_pkg.sv
// Shared constants and FSM state type for the binary64 multiplier core.
package float64_pkg;

  localparam int unsigned EXP_BIAS     = 'h3FF;
  localparam logic [10:0] EXP_MAX      = 11'h7FF;
  localparam logic [63:0] DEFAULT_NAN  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] QUIET_BIT    = 64'h0008_0000_0000_0000;
  localparam logic [31:0] FLAG_INVALID = 32'd16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_MUL,
    ST_NORM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/float64_mul_core_if.sv
// Handshake, operand and result bundle of the binary64 multiplier core.
interface float64_mul_core_if;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [31:0] float_exception_flag_i;
  logic [31:0] float_exception_flag_o;
  logic        float_exception_flag_o_ap_vld;
  logic        zSign;
  logic [12:0] zExp;
  logic [63:0] zSig;
  logic        is_special;
  logic [63:0] special_result;

  modport master (
    output ap_start, a, b, float_exception_flag_i,
    input  ap_done, ap_idle, ap_ready, float_exception_flag_o,
           float_exception_flag_o_ap_vld, zSign, zExp, zSig,
           is_special, special_result
  );

  modport slave (
    input  ap_start, a, b, float_exception_flag_i,
    output ap_done, ap_idle, ap_ready, float_exception_flag_o,
           float_exception_flag_o_ap_vld, zSign, zExp, zSig,
           is_special, special_result
  );
endinterface

// File: rtl/float64_mul_core_mul53.sv
// Radix-2 shift-add significand multiplier, one partial product per cycle.
module mul53_seq #(
  parameter int unsigned MUL_BITS = 53
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [MUL_BITS-1:0]     a_sig,
  input  logic [MUL_BITS-1:0]     b_sig,
  output logic                    busy,
  output logic                    done,
  output logic [2*MUL_BITS-1:0]   product
);
  localparam int unsigned CW = $clog2(MUL_BITS + 1);

  logic [2*MUL_BITS-1:0] mcand;
  logic [MUL_BITS-1:0]   mplier;
  logic [CW-1:0]         cnt;

  // Accumulate shifted multiplicand for each set multiplier bit, LSB first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else if (load) begin
      product <= '0;
      mcand   <= {{MUL_BITS{1'b0}}, a_sig};
      mplier  <= b_sig;
      cnt     <= CW'(MUL_BITS);
    end else if (cnt != '0) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);
  // Flags the final step so the caller can move on as the last partial
  // product lands, keeping the product usable on the very next cycle.
  assign done = (cnt == CW'(1));

endmodule

// File: rtl/float64_mul_core.sv
// Binary64 multiply front end: unpack, special-case, multiply, normalise.
module float64_mul_core #(
  parameter int unsigned MUL_BITS = 53
) (
  input logic               ap_clk,
  input logic               ap_rst_n,
  float64_mul_core_if.slave ctl
);
  import float64_pkg::*;

  state_t state, state_nxt;

  logic [63:0]           a_r, b_r;
  logic [31:0]           flag_r;
  logic                  w_sign, inv_r;
  logic [12:0]           w_exp;
  logic [52:0]           sig_a, sig_b;
  logic [12:0]           exp_a, exp_b, z_exp;
  logic                  a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic                  u_sign, u_special, u_inv;
  logic [63:0]           u_result;
  logic                  mul_load, mul_busy, mul_done;
  logic [2*MUL_BITS-1:0] product;
  logic [63:0]           n_sig;
  logic [12:0]           n_exp;

  function automatic logic [6:0] clz64(input logic [63:0] v);
    logic [6:0] n;
    logic       found;
    n     = 7'd64;
    found = 1'b0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (!found && v[63-i]) begin
        n     = 7'(i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Returns {exponent[12:0], significand[52:0]} with the leading one at bit 52.
  function automatic logic [65:0] norm_op(input logic [63:0] v);
    logic [6:0]  sh;
    logic [63:0] f;
    f = {12'b0, v[51:0]};
    if (v[62:52] == '0) begin
      sh = clz64(f) - 7'd11;
      f  = f << sh;
      return {13'd1 - {6'b0, sh}, f[52:0]};
    end
    return {2'b00, v[62:52], 1'b1, v[51:0]};
  endfunction

  assign {exp_a, sig_a} = norm_op(a_r);
  assign {exp_b, sig_b} = norm_op(b_r);
  assign z_exp  = exp_a + exp_b - 13'(EXP_BIAS);
  assign u_sign = a_r[63] ^ b_r[63];

  assign a_nan  = (a_r[62:52] == EXP_MAX) && (a_r[51:0] != '0);
  assign b_nan  = (b_r[62:52] == EXP_MAX) && (b_r[51:0] != '0);
  assign a_snan = a_nan && !a_r[51];
  assign b_snan = b_nan && !b_r[51];
  assign a_inf  = (a_r[62:52] == EXP_MAX) && (a_r[51:0] == '0);
  assign b_inf  = (b_r[62:52] == EXP_MAX) && (b_r[51:0] == '0);
  assign a_zero = (a_r[62:0] == '0);
  assign b_zero = (b_r[62:0] == '0);

  // Special-case classification and packed result (NaN > Inf > zero).
  always_comb begin
    u_special = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
    u_inv     = 1'b0;
    u_result  = '0;
    if (a_nan || b_nan) begin
      u_result = b_nan ? (b_r | QUIET_BIT) : (a_r | QUIET_BIT);
      u_inv    = a_snan || b_snan;
    end else if (a_inf || b_inf) begin
      if (a_zero || b_zero) begin
        u_result = DEFAULT_NAN;
        u_inv    = 1'b1;
      end else begin
        u_result = {u_sign, EXP_MAX, 52'b0};
      end
    end else if (a_zero || b_zero) begin
      u_result = {u_sign, 63'b0};
    end
  end

  assign mul_load = (state == ST_UNPACK) && !u_special && !mul_busy;

  mul53_seq #(.MUL_BITS(MUL_BITS)) u_mul (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .load    (mul_load),
    .a_sig   (sig_a),
    .b_sig   (sig_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  // Sticky-collapse the low product half, then one-bit normalise to bit 62.
  always_comb begin
    n_sig    = {1'b0, product[105:43]};
    n_sig[0] = n_sig[0] | (|product[42:0]);
    n_exp    = w_exp;
    if (!n_sig[62]) begin
      n_sig = n_sig << 1;
      n_exp = w_exp - 13'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (ctl.ap_start) state_nxt = ST_UNPACK;
      ST_UNPACK: state_nxt = u_special ? ST_DONE : ST_MUL;
      ST_MUL:    if (mul_done) state_nxt = ST_NORM;
      ST_NORM:   state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, working registers and result registers held until next DONE.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      a_r                <= '0;
      b_r                <= '0;
      flag_r             <= '0;
      w_sign             <= 1'b0;
      w_exp              <= '0;
      inv_r              <= 1'b0;
      ctl.zSign          <= 1'b0;
      ctl.zExp           <= '0;
      ctl.zSig           <= '0;
      ctl.is_special     <= 1'b0;
      ctl.special_result <= '0;
    end else begin
      if (state == ST_IDLE && ctl.ap_start) begin
        a_r    <= ctl.a;
        b_r    <= ctl.b;
        flag_r <= ctl.float_exception_flag_i;
      end
      if (state == ST_UNPACK) begin
        w_sign <= u_sign;
        w_exp  <= z_exp;
        inv_r  <= u_inv;
        if (u_special) begin
          ctl.zSign          <= u_sign;
          ctl.zExp           <= '0;
          ctl.zSig           <= '0;
          ctl.is_special     <= 1'b1;
          ctl.special_result <= u_result;
        end
      end
      if (state == ST_NORM) begin
        ctl.zSign          <= w_sign;
        ctl.zExp           <= n_exp;
        ctl.zSig           <= n_sig;
        ctl.is_special     <= 1'b0;
        ctl.special_result <= '0;
      end
    end
  end

  assign ctl.ap_done  = (state == ST_DONE);
  assign ctl.ap_ready = (state == ST_DONE);
  assign ctl.ap_idle  = (state == ST_IDLE) && !ctl.ap_start;
  assign ctl.float_exception_flag_o_ap_vld = (state == ST_DONE) && inv_r;
  assign ctl.float_exception_flag_o =
    ((state == ST_DONE) && inv_r) ? (flag_r | FLAG_INVALID) : flag_r;

endmodule

// File: tb/tb_float64_mul_core.sv
// Scoreboard bench for float64_mul_core with a behavioural reference model.
module tb_float64_mul_core;

  typedef struct {
    logic [63:0] a, b;
    logic        sign;
    logic [12:0] zexp;
    logic [63:0] zsig;
    logic        spec;
    logic [63:0] sres;
    logic [31:0] flag;
    logic        vld;
    int unsigned lat;
    int unsigned start;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  exp_t sb[$];
  exp_t mon_e;

  float64_mul_core_if bus ();

  float64_mul_core #(.MUL_BITS(53)) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .ctl      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  function automatic void unpack(input logic [63:0] v, output logic [127:0] m, output int x);
    if (v[62:52] == 11'd0) begin
      m = {76'd0, v[51:0]};
      x = 1;
      while (!m[52]) begin
        m = m << 1;
        x = x - 1;
      end
    end else begin
      m = {75'd0, 1'b1, v[51:0]};
      x = int'(v[62:52]);
    end
  endfunction

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic [31:0] f);
    exp_t e;
    logic na, nb, sna, snb, ia, ib, za, zb;
    logic [127:0] ma, mb, p;
    int xa, xb, ze;
    logic [63:0] zs;
    e = '{default: 0};
    e.a = a; e.b = b;
    na  = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
    nb  = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
    sna = na && !a[51];
    snb = nb && !b[51];
    ia  = (a[62:52] == 11'h7FF) && (a[51:0] == 0);
    ib  = (b[62:52] == 11'h7FF) && (b[51:0] == 0);
    za  = (a[62:0] == 0);
    zb  = (b[62:0] == 0);
    e.sign = a[63] ^ b[63];
    if (na || nb) begin
      e.spec = 1'b1;
      e.sres = nb ? (b | 64'h0008_0000_0000_0000) : (a | 64'h0008_0000_0000_0000);
      e.vld  = sna || snb;
    end else if (ia || ib) begin
      e.spec = 1'b1;
      if (za || zb) begin
        e.sres = 64'h7FFF_FFFF_FFFF_FFFF;
        e.vld  = 1'b1;
      end else begin
        e.sres = {e.sign, 11'h7FF, 52'd0};
      end
    end else if (za || zb) begin
      e.spec = 1'b1;
      e.sres = {e.sign, 63'd0};
    end else begin
      unpack(a, ma, xa);
      unpack(b, mb, xb);
      p  = ma * mb;
      ze = xa + xb - 1023;
      zs = {1'b0, p[105:43]};
      if (p[42:0] != 0) zs[0] = 1'b1;
      if (!zs[62]) begin
        zs = zs << 1;
        ze = ze - 1;
      end
      e.zexp = 13'(ze);
      e.zsig = zs;
    end
    e.flag = e.vld ? (f | 32'd16) : f;
    e.lat  = e.spec ? 2 : 56;
    return e;
  endfunction

  function automatic logic [63:0] rand_op();
    logic [51:0] fr;
    logic        s;
    int unsigned cls;
    fr  = 52'({$urandom, $urandom});
    s   = 1'($urandom_range(0, 1));
    cls = $urandom_range(0, 11);
    case (cls)
      6:       return {s, 11'd0, (fr >> $urandom_range(0, 51)) | 52'd1};
      7:       return {s, 63'd0};
      8:       return {s, 11'h7FF, 52'd0};
      9:       return {s, 11'h7FF, fr | 52'h8_0000_0000_0000};
      10:      return {s, 11'h7FF, (fr & 52'h7_FFFF_FFFF_FFFF) | 52'd1};
      11:      return {s, 11'h3FF, fr};
      default: return {s, 11'($urandom_range(1, 2046)), fr};
    endcase
  endfunction

  // Monitor: every ap_done pops one expectation and compares all result fields.
  always @(negedge clk) begin
    if (rst_n && bus.ap_done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done at cycle %0d: got ap_done=1 expected 0", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("latency", 64'(cyc - mon_e.start), 64'(mon_e.lat));
        chk("ap_ready", 64'(bus.ap_ready), 64'd1);
        chk("zSign", 64'(bus.zSign), 64'(mon_e.sign));
        chk("is_special", 64'(bus.is_special), 64'(mon_e.spec));
        chk("special_result", bus.special_result, mon_e.sres);
        chk("flag_o", 64'(bus.float_exception_flag_o), 64'(mon_e.flag));
        chk("flag_vld", 64'(bus.float_exception_flag_o_ap_vld), 64'(mon_e.vld));
        if (!mon_e.spec) begin
          chk("zExp", 64'(bus.zExp), 64'(mon_e.zexp));
          chk("zSig", bus.zSig, mon_e.zsig);
        end
      end
    end
  end

  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic [31:0] f,
                          input bit push);
    exp_t e;
    int unsigned n = 0;
    while (!bus.ap_idle && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ap_idle) chk("idle_timeout", 64'(bus.ap_idle), 64'd1);
    bus.a = a;
    bus.b = b;
    bus.float_exception_flag_i = f;
    bus.ap_start = 1'b1;
    if (push) begin
      e = model(a, b, f);
      e.start = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.ap_start = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic run(input logic [63:0] a, input logic [63:0] b, input logic [31:0] f);
    start_op(a, b, f, 1'b1);
    wait_drain();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_done"}, 64'(bus.ap_done), 64'd0);
    chk({tag, "_idle"}, 64'(bus.ap_idle), 64'd1);
    chk({tag, "_zSig"}, bus.zSig, 64'd0);
    chk({tag, "_zExp"}, 64'(bus.zExp), 64'd0);
    chk({tag, "_zSign"}, 64'(bus.zSign), 64'd0);
    chk({tag, "_special"}, 64'(bus.is_special), 64'd0);
    chk({tag, "_sres"}, bus.special_result, 64'd0);
    chk({tag, "_flag_o"}, 64'(bus.float_exception_flag_o), 64'd0);
    chk({tag, "_vld"}, 64'(bus.float_exception_flag_o_ap_vld), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ap_start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.float_exception_flag_i = '0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 32'h0);
    run(64'hC000_0000_0000_0000, 64'h4008_0000_0000_0000, 32'h100);
    run(64'h7FF0_0000_0000_0000, 64'h0,                   32'h1);
    run(64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000, 32'h0);
    run(64'h0000_0000_0000_0001, 64'h3FF0_0000_0000_0000, 32'h0);
    run(64'h7FF8_0000_0000_0000, 64'h7FF0_0000_0000_0005, 32'h2);
    run(64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 32'h4);
    run(64'hFFF0_0000_0000_0000, 64'h4000_0000_0000_0000, 32'h0);

    for (int unsigned i = 0; i < 40; i++)
      run(rand_op(), rand_op(), 32'($urandom_range(0, 15)));

    // Second ap_start during MUL must be ignored; operands latched at start.
    start_op(64'h4010_0000_0000_0003, 64'hBFF8_0000_0000_0001, 32'h8, 1'b1);
    repeat (10) @(negedge clk);
    chk("flag_o_busy", 64'(bus.float_exception_flag_o), 64'h8);
    chk("vld_busy", 64'(bus.float_exception_flag_o_ap_vld), 64'd0);
    bus.a = 64'h3FF0_0000_0000_0000;
    bus.b = 64'h7FF0_0000_0000_0000;
    bus.ap_start = 1'b1;
    @(negedge clk);
    bus.ap_start = 1'b0;
    wait_drain();
    repeat (70) @(negedge clk);

    // Reset at MUL cycle 20 aborts the operation without ap_done.
    start_op(64'h4005_5555_5555_5555, 64'h3FE1_2345_6789_ABCD, 32'h3, 1'b0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_zero_outputs("midreset");
    repeat (70) @(negedge clk);
    run(64'h4005_5555_5555_5555, 64'h3FE1_2345_6789_ABCD, 32'h3);
    run(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/float64_mul_core.md
FLOAT64_MUL_CORE -- requirements
Module: float64_mul_core

Interface
REQ-001 Parameter MUL_BITS, default 53, significand width iterated by the shift-add multiplier.
REQ-002 ap_clk  input  1  sole clock, all logic on rising edge.
REQ-003 ap_rst_n  input  1  reset, synchronous, active-low.
REQ-004 ap_start  input  1  request; sampled only in IDLE.
REQ-005 ap_done  output  1  one-cycle pulse, result valid.
REQ-006 ap_idle  output  1  high in IDLE while ap_start low.
REQ-007 ap_ready  output  1  equal to ap_done.
REQ-008 a, b  input  64 each  IEEE-754 binary64 operands.
REQ-009 float_exception_flag_i  input  32  incoming sticky flags.
REQ-010 float_exception_flag_o  output  32  updated flags; float_exception_flag_o_ap_vld  output  1  write strobe.
REQ-011 zSign  output  1; zExp  output  13 (two's complement); zSig  output  64; these feed the downstream round-and-pack stage.
REQ-012 is_special  output  1  result bypasses rounding; special_result  output  64  packed final result.

Function
REQ-013 States IDLE, UNPACK, MUL, NORM, DONE; IDLE->UNPACK on ap_start; a, b and flag_i latched on that edge.
REQ-014 ap_start outside IDLE ignored; no queuing.
REQ-015 UNPACK: zSign = a[63]^b[63]; any operand with exponent 0x7FF, or zero operand, sets is_special and goes to DONE; otherwise go to MUL.
REQ-016 NaN operand (exponent 0x7FF, fraction non-zero): result = b|0x0008000000000000 if b is NaN, else a|0x0008000000000000; invalid if either operand is signaling (fraction bit 51 = 0).
REQ-017 Infinity times zero: result 0x7FFFFFFFFFFFFFFF, invalid; infinity otherwise: {zSign, 0x7FF, 52'b0}.
REQ-018 Zero operand (exponent 0, fraction 0), other operand finite: result {zSign, 63'b0}, no flag.
REQ-019 Subnormal operand: shift = clz64(fraction) - 11, fraction <<= shift, exponent = 1 - shift (signed).
REQ-020 zExp = aExp + bExp - 0x3FF in 13-bit signed; range -1125..3071 never wraps.
REQ-021 MUL: 53x53 radix-2 shift-add on {1,fracA} x {1,fracB}, one partial product per cycle, exactly 53 cycles, 106-bit product P.
REQ-022 NORM: zSig = {1'b0, P[105:43]} with bit 0 ORed with |P[42:0]; if zSig[62]==0, zSig <<= 1 and zExp -= 1.
REQ-023 DONE: ap_done = ap_ready = 1 for one cycle, then IDLE; outputs held until the next DONE.
REQ-024 Invalid: float_exception_flag_o = flag_i | 32'd16 and ap_vld = 1 in DONE only; otherwise flag_o = flag_i and ap_vld = 0.
REQ-025 Latency, start cycle = 0: normal path ap_done at cycle 56; special path ap_done at cycle 2.
REQ-026 Non-special path: is_special = 0, special_result = 0.

Reset
REQ-027 ap_rst_n low at a clock edge: state IDLE, all outputs and data registers zero, ap_idle follows REQ-006.
REQ-028 Reset during MUL aborts the operation; no ap_done for it; the next ap_start behaves as if first after power-up.

Structure
REQ-029 Shared package float64_pkg: EXP_BIAS 0x3FF, DEFAULT_NAN 0x7FFFFFFFFFFFFFFF, QUIET_BIT mask, FLAG_INVALID 16, FSM state enum.
REQ-030 One sub-module mul53_seq (load, busy, done, 106-bit product); clz64 stays inline as a function.

Verification
REQ-031 a=b=0x3FF0000000000000 -> zSign 0, zExp 1022, zSig 0x4000000000000000, is_special 0, ap_done at cycle 56.
REQ-032 a=0xC000000000000000, b=0x4008000000000000 -> zSign 1, zExp 1024, zSig 0x6000000000000000.
REQ-033 a=0x7FF0000000000000, b=0 -> is_special 1, special_result 0x7FFFFFFFFFFFFFFF, flag_o = flag_i|16, ap_vld 1, ap_done at cycle 2.
REQ-034 a=0x7FF0000000000001, b=0x3FF0000000000000 -> special_result 0x7FF8000000000001, invalid raised.
REQ-035 a=0x0000000000000001, b=1.0 -> zExp 0x1FCC (-52), zSig 0x4000000000000000.
REQ-036 Second ap_start mid-MUL ignored; ap_rst_n low at MUL cycle 20 -> no ap_done, outputs zero, next operation correct.
